riego_valve_sequencer: RTL and testbench



---
 rtl/riego_pkg.sv | 13 +
 rtl/riego_valve_sequencer_if.sv | 17 +
 rtl/valve_on_timer.sv | 18 +
 rtl/riego_valve_sequencer.sv | 85 ++++++++
 tb/tb_riego_valve_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/riego_pkg.sv
// riego_pkg: shared state encoding, level/fault codes and valve count for the valve sequencer.
package riego_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FAULT} state_t;
  localparam logic [1:0] ERR_CODE = 2'b00;
  localparam logic [1:0] NE_CODE = 2'b01;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_LEVEL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam int N_VALVES = 4;
  function automatic logic [N_VALVES-1:0] first_set(input logic [N_VALVES-1:0] v);
    return v & (~v + 1'b1);
  endfunction
endpackage

// File: rtl/riego_valve_sequencer_if.sv
// riego_valve_sequencer_if: controller requests in, valve/pump/fault drives out.
// fault_cause exists only when RIEGO_FAULT_CAUSE_EN is defined.
interface riego_valve_sequencer_if;
  import riego_pkg::*;
  logic [1:0] R1, R2, E;
  logic clear_fault;
  logic [N_VALVES-1:0] valve;
  logic pump, fault;
`ifdef RIEGO_FAULT_CAUSE_EN
  logic [1:0] fault_cause;
  modport master (output R1, R2, E, clear_fault, input valve, pump, fault, fault_cause);
  modport slave (input R1, R2, E, clear_fault, output valve, pump, fault, fault_cause);
`else
  modport master (output R1, R2, E, clear_fault, input valve, pump, fault);
  modport slave (input R1, R2, E, clear_fault, output valve, pump, fault);
`endif
endinterface

// File: rtl/valve_on_timer.sv
// valve_on_timer: saturating on-time counter, cleared on valve opening; min_reached means closing is allowed at this edge.
module valve_on_timer #(
  parameter int MIN_ON = 16,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic min_reached
);
  logic [CNT_W-1:0] cnt;
  // counts the current cycle too, so a valve stays open exactly MIN_ON cycles at minimum
  assign min_reached = ({1'b0, cnt} + 1'b1) >= (CNT_W+1)'(MIN_ON);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != CNT_W'(MIN_ON)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/riego_valve_sequencer.sv
// riego_valve_sequencer: pump priming, staggered valve opening, minimum on-time, run watchdog and fault latch.
// Defining RIEGO_FAULT_CAUSE_EN adds the latched fault_cause output.
module riego_valve_sequencer
  import riego_pkg::*;
#(
  parameter int PUMP_DELAY = 8,
  parameter int STAGGER = 4,
  parameter int MIN_ON = 16,
  parameter int MAX_RUN = 1024,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  riego_valve_sequencer_if.slave io
);
  state_t state, state_n;
  logic [N_VALVES-1:0] req, valve, valve_n, open, min_reached;
  logic pump, pump_n, fault, fault_n, err, stg_ok, prime_done, timeout;
  logic [CNT_W-1:0] prime_cnt, stg_cnt, stg_n, run_cnt;
  assign req = {io.R2, io.R1};
  assign err = io.E == ERR_CODE;
  assign stg_ok = stg_cnt >= CNT_W'(STAGGER - 1);
  assign prime_done = prime_cnt == CNT_W'(PUMP_DELAY - 1);
  assign timeout = run_cnt == CNT_W'(MAX_RUN - 1);
  assign stg_n = |open ? '0 : stg_ok ? stg_cnt : stg_cnt + 1'b1;
  assign io.valve = valve;
  assign io.pump = pump;
  assign io.fault = fault;
  for (genvar i = 0; i < N_VALVES; i++) begin : g_tmr
    valve_on_timer #(.MIN_ON(MIN_ON), .CNT_W(CNT_W)) u_tmr (
      .clk(clk), .reset(reset), .clr(open[i]), .min_reached(min_reached[i])
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      valve <= '0;
      pump <= 1'b0;
      fault <= 1'b0;
      prime_cnt <= '0;
      stg_cnt <= '0;
      run_cnt <= '0;
    end else begin
      state <= state_n;
      valve <= valve_n;
      pump <= pump_n;
      fault <= fault_n;
      prime_cnt <= state == PRIME ? prime_cnt + 1'b1 : '0;
      stg_cnt <= stg_n;
      run_cnt <= state == RUN ? run_cnt + 1'b1 : '0;
    end
  always_comb begin
    state_n = state;
    pump_n = pump;
    fault_n = fault;
    open = '0;
    unique case (state)
      IDLE: if (req != '0) begin state_n = PRIME; pump_n = 1'b1; end
      PRIME:
        if (req == '0) begin state_n = IDLE; pump_n = 1'b0; end
        else if (prime_done) begin state_n = RUN; open = first_set(req); end
      RUN:
        if (timeout) begin state_n = FAULT; pump_n = 1'b0; fault_n = 1'b1; end
        else if (valve == '0 && req == '0) begin state_n = IDLE; pump_n = 1'b0; end
        else open = stg_ok ? first_set(req & ~valve) : '0;
      FAULT: if (io.clear_fault && !err) begin state_n = IDLE; fault_n = 1'b0; end
    endcase
    // a level error overrides everything outside FAULT, including min on-time
    if (err && state != FAULT) begin
      state_n = FAULT;
      pump_n = 1'b0;
      fault_n = 1'b1;
      open = '0;
    end
    valve_n = state_n == RUN ? (valve & (req | ~min_reached)) | open : '0;
  end
`ifdef RIEGO_FAULT_CAUSE_EN
  logic [1:0] cause;
  always_ff @(posedge clk or posedge reset)
    if (reset) cause <= CAUSE_NONE;
    else if (state != FAULT && state_n == FAULT) cause <= err ? CAUSE_LEVEL : CAUSE_TIMEOUT;
    else if (state == FAULT && state_n == IDLE) cause <= CAUSE_NONE;
  assign io.fault_cause = cause;
`endif
endmodule

// File: tb/tb_riego_valve_sequencer.sv
// tb_riego_valve_sequencer: directed scenarios plus random traffic checked against a timestamp-based reference model.
module tb_riego_valve_sequencer;
  import riego_pkg::*;
  localparam int PUMP_DELAY = 8, STAGGER = 4, MIN_ON = 16, MAX_RUN = 1024;
  logic clk = 1'b0, reset = 1'b0;
  riego_valve_sequencer_if bus();
  riego_valve_sequencer dut (.clk(clk), .reset(reset), .io(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mode, prime_start, run_start, last_open;
  int open_at[4];
  logic [3:0] m_valve;
  logic m_pump, m_fault;
  logic [1:0] m_cause;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] e, input logic clr);
    bus.R1 = r1;
    bus.R2 = r2;
    bus.E = e;
    bus.clear_fault = clr;
  endtask
  task automatic model_reset();
    mode = 0;
    m_valve = '0;
    m_pump = 1'b0;
    m_fault = 1'b0;
    m_cause = 2'b00;
    cyc = 0;
  endtask
  task automatic open_first(input logic [3:0] pend);
    bit done = 0;
    for (int i = 0; i < 4; i++)
      if (!done && pend[i]) begin
        m_valve[i] = 1'b1;
        open_at[i] = cyc;
        last_open = cyc;
        done = 1;
      end
  endtask
  task automatic go_fault(input logic [1:0] c);
    mode = 3;
    m_valve = '0;
    m_pump = 1'b0;
    m_fault = 1'b1;
    m_cause = c;
  endtask
  // mode: 0 idle, 1 priming, 2 running, 3 faulted; timing kept as edge timestamps
  task automatic model_edge();
    logic [3:0] req, nv, pend;
    bit err;
    req = {bus.R2, bus.R1};
    err = bus.E == 2'b00;
    cyc++;
    if (mode != 3 && err) go_fault(2'b01);
    else if (mode == 0) begin
      if (req != 0) begin mode = 1; prime_start = cyc; m_pump = 1'b1; end
    end else if (mode == 1) begin
      if (req == 0) begin mode = 0; m_pump = 1'b0; end
      else if (cyc - prime_start == PUMP_DELAY) begin
        mode = 2;
        run_start = cyc;
        m_valve = '0;
        open_first(req);
      end
    end else if (mode == 2) begin
      if (cyc - run_start == MAX_RUN) go_fault(2'b10);
      else if (m_valve == 0 && req == 0) begin mode = 0; m_pump = 1'b0; end
      else begin
        nv = m_valve;
        for (int i = 0; i < 4; i++)
          if (m_valve[i] && !req[i] && cyc - open_at[i] >= MIN_ON) nv[i] = 1'b0;
        pend = req & ~m_valve;
        m_valve = nv;
        if (cyc - last_open >= STAGGER) open_first(pend);
      end
    end else if (bus.clear_fault && !err) begin
      mode = 0;
      m_fault = 1'b0;
      m_cause = 2'b00;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check($sformatf("valve@%0d", cyc), 32'(bus.valve), 32'(m_valve));
    check($sformatf("pump@%0d", cyc), 32'(bus.pump), 32'(m_pump));
    check($sformatf("fault@%0d", cyc), 32'(bus.fault), 32'(m_fault));
`ifdef RIEGO_FAULT_CAUSE_EN
    check($sformatf("cause@%0d", cyc), 32'(bus.fault_cause), 32'(m_cause));
`endif
  endtask
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("async_rst_valve", 32'(bus.valve), 32'h0);
    check("async_rst_pump", 32'(bus.pump), 32'h0);
    check("async_rst_fault", 32'(bus.fault), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    set_in(2'b01, 2'b00, 2'b01, 1'b0);
    #1;
    apply_reset();
    tick();
    check("s1_pump_c1", 32'(bus.pump), 32'h1);
    repeat (7) tick();
    check("s1_valve_c8", 32'(bus.valve), 32'h0);
    tick();
    check("s1_valve_c9", 32'(bus.valve), 32'h1);
    check("s1_fault", 32'(bus.fault), 32'h0);
    set_in(2'b11, 2'b11, 2'b01, 1'b0);
    apply_reset();
    repeat (20) tick();
    check("s2_valve_c20", 32'(bus.valve), 32'h7);
    tick();
    check("s2_valve_c21", 32'(bus.valve), 32'hF);
    set_in(2'b01, 2'b00, 2'b01, 1'b0);
    apply_reset();
    repeat (14) tick();
    bus.R1 = 2'b00;
    repeat (10) tick();
    check("s3_still_open_c24", 32'(bus.valve), 32'h1);
    tick();
    check("s3_closed_c25", 32'(bus.valve), 32'h0);
    check("s3_pump_c25", 32'(bus.pump), 32'h1);
    tick();
    check("s3_pump_off_c26", 32'(bus.pump), 32'h0);
    set_in(2'b11, 2'b00, 2'b01, 1'b0);
    apply_reset();
    repeat (13) tick();
    check("s4_valve_c13", 32'(bus.valve), 32'h3);
    bus.E = 2'b00;
    tick();
    check("s4_err_valve", 32'(bus.valve), 32'h0);
    check("s4_err_fault", 32'(bus.fault), 32'h1);
    bus.clear_fault = 1'b1;
    repeat (3) tick();
    check("s4_clear_ignored", 32'(bus.fault), 32'h1);
    set_in(2'b00, 2'b00, 2'b01, 1'b1);
    tick();
    check("s4_cleared", 32'(bus.fault), 32'h0);
    bus.clear_fault = 1'b0;
    tick();
    check("s4_idle_pump", 32'(bus.pump), 32'h0);
    set_in(2'b01, 2'b00, 2'b01, 1'b0);
    apply_reset();
    repeat (1032) tick();
    check("s5_no_fault_yet", 32'(bus.fault), 32'h0);
    tick();
    check("s5_timeout_fault", 32'(bus.fault), 32'h1);
    check("s5_timeout_valve", 32'(bus.valve), 32'h0);
`ifdef RIEGO_FAULT_CAUSE_EN
    check("s5_cause", 32'(bus.fault_cause), 32'h2);
`endif
    set_in(2'b00, 2'b00, 2'b01, 1'b1);
    tick();
    set_in(2'b01, 2'b01, 2'b01, 1'b0);
    apply_reset();
    repeat (15) tick();
    check("s6_valve_c15", 32'(bus.valve), 32'h5);
    apply_reset();
    tick();
    check("s6_pump_c1", 32'(bus.pump), 32'h1);
    repeat (8) tick();
    check("s6_valve_c9", 32'(bus.valve), 32'h1);
    apply_reset();
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.R1 = 2'($urandom_range(0, 3));
        bus.R2 = 2'($urandom_range(0, 3));
      end
      bus.E = $urandom_range(0, 59) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
      bus.clear_fault = $urandom_range(0, 3) == 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
